// File: rtl/readout_pkg.sv
// Shared types for the sample-memory readout sequencer.
package readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GUARD = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam int LAT_W = $clog2(8);

endpackage

// File: rtl/readout_addr_gen.sv
// Readout address/word-count tracker: walks addresses downward
// with modulo wrap and flags the final word.
module readout_addr_gen
  import readout_pkg::*;
#(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] load_addr,
  input  logic [AW-1:0] load_cnt,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remain_q, remain_d;

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load) begin
      addr_d   = load_addr;
      remain_d = load_cnt;
    end else if (dec) begin
      addr_d   = addr_q - ONE;
      remain_d = remain_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr = addr_q;
  assign last = (remain_q == '0);

endmodule

// File: rtl/readout_ctrl.sv
// Drains sample memory to the transmitter, newest word first,
// one read per word with busy handshaking and abort.
module readout_ctrl
  import readout_pkg::*;
#(
  parameter int MDW  = 32,
  parameter int AW   = 17,
  parameter int RDLY = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  input  logic           abort,
  input  logic [AW-1:0]  last_addr,
  input  logic [AW-1:0]  read_count,
  output logic [AW-1:0]  mem_addr,
  output logic           mem_rd,
  input  logic [MDW-1:0] mem_rdata,
  output logic [MDW-1:0] tx_data,
  output logic           tx_send,
  input  logic           tx_busy,
  output logic           active,
  output logic           done
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RDLY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [MDW-1:0]   tx_data_q, tx_data_d;
  logic             mem_rd_q, mem_rd_d;
  logic             tx_send_q, tx_send_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             ag_load;
  logic             ag_dec;
  logic             ag_last;
  logic [AW-1:0]    ag_addr;

  readout_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (ag_load),
    .dec       (ag_dec),
    .load_addr (last_addr),
    .load_cnt  (read_count),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    ag_load   = 1'b0;
    ag_dec    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          ag_load = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        lat_d   = LAT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          tx_data_d = mem_rdata;
          tx_send_d = !tx_busy;
          state_d   = ST_SEND;
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end
      // tx_send is registered, so the strobe is decided a cycle early
      ST_SEND: begin
        if (tx_send_q) state_d = ST_GUARD;
        else tx_send_d = !tx_busy;
      end
      ST_GUARD: state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tx_busy) begin
          if (ag_last) begin
            state_d = ST_DONE;
          end else begin
            ag_dec  = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      tx_send_d = 1'b0;
      tx_data_d = tx_data_q;
      ag_dec    = 1'b0;
    end

    mem_rd_d = (state_d == ST_READ);
    active_d = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      lat_q     <= '0;
      tx_data_q <= '0;
      mem_rd_q  <= 1'b0;
      tx_send_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      tx_data_q <= tx_data_d;
      mem_rd_q  <= mem_rd_d;
      tx_send_q <= tx_send_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr = ag_addr;
  assign mem_rd   = mem_rd_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign active   = active_q;
  assign done     = done_q;

endmodule
